// File: rtl/queue_serial_tx_pkg.sv
// Shared constants, state encoding and entry helpers for the queue serial dump.
package queue_serial_tx_pkg;

    localparam int ENTRY_W     = 7;
    localparam int QUEUE_DEPTH = 16;
    localparam int ADDR_W      = 4;

    // Field positions inside a queue entry word
    localparam int EH_ORIGEM_BIT = 6;
    localparam int TIPO_HI       = 5;
    localparam int TIPO_LO       = 4;
    localparam int ORIGEM_HI     = 3;
    localparam int ORIGEM_LO     = 2;
    localparam int DESTINO_HI    = 1;
    localparam int DESTINO_LO    = 0;

    // End-of-dump marker; bit 7 of an entry byte is always 0 so it cannot collide
    localparam logic [7:0] TERM_BYTE_DEF = 8'hFF;

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(QUEUE_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RAM = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SEND     = 3'd3,
        ST_TERM     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Rebuild the raw RAM word from the split read-port buses
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic eh_origem,
                                                     input logic [5:0] dados);
        logic [ENTRY_W-1:0] w;
        w = 7'b0000000;
        w[EH_ORIGEM_BIT]         = eh_origem;
        w[TIPO_HI:TIPO_LO]       = dados[TIPO_HI:TIPO_LO];
        w[ORIGEM_HI:ORIGEM_LO]   = dados[ORIGEM_HI:ORIGEM_LO];
        w[DESTINO_HI:DESTINO_LO] = dados[DESTINO_HI:DESTINO_LO];
        return w;
    endfunction

    // Transmitted byte for an occupied entry: the word zero-extended
    function automatic logic [7:0] entry_byte(input logic [ENTRY_W-1:0] w);
        return {1'b0, w};
    endfunction

endpackage

// File: rtl/queue_serial_tx_uart.sv
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
// done pulses during the last stop-bit cycle; tx is registered and idles high.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

    logic [9:0]        frame_q;
    logic [3:0]        bit_q;
    logic [BAUD_W-1:0] baud_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    // Frame shifter with baud and bit counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_q <= 10'h3FF;
            bit_q   <= 4'd0;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start) begin
                    frame_q <= {1'b1, data, 1'b0};
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    baud_q  <= '0;
                    bit_q   <= 4'd0;
                end else begin
                    tx_q <= 1'b1;
                end
            end else if (baud_q == BAUD_LAST) begin
                baud_q <= '0;
                if (bit_q == 4'd9) begin
                    busy_q <= 1'b0;
                    tx_q   <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    tx_q    <= frame_q[1];
                    frame_q <= {1'b1, frame_q[9:1]};
                end
            end else begin
                baud_q <= baud_q + BAUD_W'(1);
                // Raise done so it is high exactly in the final stop-bit cycle
                if ((bit_q == 4'd9) && (baud_q == BAUD_PRE)) begin
                    done_q <= 1'b1;
                end else begin
                    done_q <= 1'b0;
                end
            end
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/queue_serial_tx.sv
// Scans the cargo request queue through its serial read port and sends each
// occupied entry as one UART byte, followed by a terminator byte.
module queue_serial_tx
    import queue_serial_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] TERM_BYTE    = TERM_BYTE_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [3:0] addr_serial,
    input  logic [5:0] dados_addr_serial,
    input  logic       eh_origem_addr_serial,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [4:0] count
);

    state_e               state_q;
    logic [ADDR_W-1:0]    index_q;
    logic [4:0]           count_q;
    logic [7:0]           byte_q;
    logic                 uart_start_q;
    logic                 busy_q;
    logic                 done_q;
    logic [ENTRY_W-1:0]   ram_word_s;
    logic                 uart_busy_s;
    logic                 uart_done_s;

    assign ram_word_s = pack_entry(eh_origem_addr_serial, dados_addr_serial);

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (uart_start_q),
        .data   (byte_q),
        .tx     (tx),
        .busy   (uart_busy_s),
        .done   (uart_done_s)
    );

    // Scan FSM: address the RAM, wait one read cycle, latch, transmit, repeat
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            index_q      <= 4'd0;
            count_q      <= 5'd0;
            byte_q       <= 8'h00;
            uart_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            uart_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !uart_busy_s) begin
                        index_q <= 4'd0;
                        count_q <= 5'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT_RAM;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT_RAM: begin
                    state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    // The word is captured here; later RAM changes cannot alter it
                    uart_start_q <= 1'b1;
                    if (ram_word_s == 7'b0000000) begin
                        byte_q  <= TERM_BYTE;
                        state_q <= ST_TERM;
                    end else begin
                        byte_q  <= entry_byte(ram_word_s);
                        count_q <= count_q + 5'd1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uart_done_s) begin
                        if (index_q == LAST_INDEX) begin
                            byte_q       <= TERM_BYTE;
                            uart_start_q <= 1'b1;
                            state_q      <= ST_TERM;
                        end else begin
                            index_q <= index_q + 4'd1;
                            state_q <= ST_WAIT_RAM;
                        end
                    end else begin
                        state_q <= ST_SEND;
                    end
                end
                ST_TERM: begin
                    if (uart_done_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_TERM;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign addr_serial = index_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign count       = count_q;

endmodule
